coin_burst_sequencer: RTL and testbench

Upstream front end for the vending machine FSM. Conditions two raw coin-sensor lines (5 rs, 10 rs), debounces them, and buffers accepted coins in a small FIFO. On a commit request, idle timeout or full buffer, it replays the stored coins as a gap-free burst of 2-bit coin codes (01 = 5 rs, 10 = 10 rs) on consecutive cycles, followed by one 00 cycle. This suits the downstream FSM, which treats any 00 cycle as "end of payment".

---
 rtl/coin_burst_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_coin_burst_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/coin_burst_sequencer.sv
// Coin front end: synchronizes and debounces two coin sensors, buffers accepted
// coins in a small FIFO and replays them as a gap-free burst of codes ended by 00.
module coin_burst_sequencer #(
  parameter int DEB_CYCLES   = 16,
  parameter int IDLE_TIMEOUT = 1000,
  parameter int DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     coin5_raw,
  input  logic                     coin10_raw,
  input  logic                     commit,
  output logic [1:0]               coin_code,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     reject
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYCLES);
  localparam logic [TW-1:0] TIMER_MAX = TW'(IDLE_TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX   = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    BURST   = 2'b10,
    GAP     = 2'b11
  } state_t;

  state_t          state_r, state_nxt_s;
  logic [1:0]      sync1_r, sync2_r;
  logic [DW-1:0]   deb_cnt_r [2];
  logic [1:0]      deb_prev_r, deb_lvl_s, event_s;
  logic [TW-1:0]   timer_r, timer_nxt_s;
  logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
  logic [CW-1:0]   count_r, count_after_s, count_nxt_s;
  logic [1:0]      fifo_r [DEPTH];
  logic [1:0]      code_r, code_nxt_s, push_code_s;
  logic            busy_r, full_r, reject_r;
  logic            push_s, pop_s, rej_s, open_s;

  // Two-flop synchronizers and saturating debounce counters; bit 0 is 5 rs, bit 1 is 10 rs
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_r    <= 2'b00;
      sync2_r    <= 2'b00;
      deb_prev_r <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        deb_cnt_r[c] <= {DW{1'b0}};
      end
    end else begin
      sync1_r    <= {coin10_raw, coin5_raw};
      sync2_r    <= sync1_r;
      deb_prev_r <= deb_lvl_s;
      for (int c = 0; c < 2; c++) begin
        if (!sync2_r[c]) begin
          deb_cnt_r[c] <= {DW{1'b0}};
        end else if (deb_cnt_r[c] != DEB_MAX) begin
          deb_cnt_r[c] <= deb_cnt_r[c] + DW'(1);
        end else begin
          deb_cnt_r[c] <= deb_cnt_r[c];
        end
      end
    end
  end

  // Debounced levels and their rising edges (one event per physical coin)
  always_comb begin
    deb_lvl_s = 2'b00;
    for (int c = 0; c < 2; c++) begin
      deb_lvl_s[c] = (deb_cnt_r[c] == DEB_MAX);
    end
    event_s = deb_lvl_s & ~deb_prev_r;
  end

  // Acceptance decision, sequencer next state, idle timer and burst pop
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    rej_s       = 1'b0;
    code_nxt_s  = 2'b00;
    open_s      = (state_r == IDLE) || (state_r == COLLECT);
    push_code_s = event_s[0] ? 2'b01 : 2'b10;

    if (event_s != 2'b00) begin
      if ((event_s != 2'b11) && open_s && (count_r < CNT_MAX)) begin
        push_s = 1'b1;
      end else begin
        rej_s = 1'b1;
      end
    end else begin
      push_s = 1'b0;
    end
    count_after_s = count_r + CW'(push_s);

    case (state_r)
      IDLE: begin
        if (push_s) begin
          state_nxt_s = COLLECT;
          timer_nxt_s = TIMER_MAX;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      COLLECT: begin
        if (push_s) begin
          timer_nxt_s = TIMER_MAX;
        end else if (timer_r != {TW{1'b0}}) begin
          timer_nxt_s = timer_r - TW'(1);
        end else begin
          timer_nxt_s = timer_r;
        end
        // A coin landing in the same cycle as the trigger is already counted here
        if (commit || (timer_r == {TW{1'b0}}) || (count_after_s == CNT_MAX)) begin
          state_nxt_s = BURST;
        end else begin
          state_nxt_s = COLLECT;
        end
      end
      BURST: begin
        if (count_r != {CW{1'b0}}) begin
          pop_s      = 1'b1;
          code_nxt_s = fifo_r[rd_ptr_r];
        end else begin
          state_nxt_s = GAP;
        end
      end
      GAP: begin
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    count_nxt_s = count_after_s - CW'(pop_s);
  end

  // State, pointers, occupancy and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r  <= IDLE;
      timer_r  <= {TW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      code_r   <= 2'b00;
      busy_r   <= 1'b0;
      full_r   <= 1'b0;
      reject_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      timer_r  <= timer_nxt_s;
      wr_ptr_r <= push_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      rd_ptr_r <= pop_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
      count_r  <= count_nxt_s;
      code_r   <= code_nxt_s;
      busy_r   <= (state_nxt_s == BURST) || (state_nxt_s == GAP);
      full_r   <= (count_nxt_s == CNT_MAX);
      reject_r <= rej_s;
    end
  end

  // FIFO storage; contents need no reset because the pointers define validity
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_r[wr_ptr_r] <= push_code_s;
    end else begin
      fifo_r[wr_ptr_r] <= fifo_r[wr_ptr_r];
    end
  end

  assign coin_code = code_r;
  assign busy      = busy_r;
  assign count     = count_r;
  assign full      = full_r;
  assign reject    = reject_r;

endmodule

// File: tb/tb_coin_burst_sequencer.sv
// Self-checking bench for coin_burst_sequencer: directed scenarios plus random coins,
// compared every cycle against a queue-based behavioural model.
module tb_coin_burst_sequencer;

  localparam int D     = 16;
  localparam int TO    = 20;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst, coin5_raw, coin10_raw, commit;
  logic [1:0]    coin_code;
  logic          busy, full, reject;
  logic [CW-1:0] count;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state
  int   q[$];
  bit   bursting, in_gap;
  int   quiet;
  int   run5, run10;
  bit [2:0] hit5, hit10;
  int   exp_code, exp_busy, exp_count, exp_full, exp_rej;
  int   rejects_seen;

  coin_burst_sequencer #(.DEB_CYCLES(D), .IDLE_TIMEOUT(TO), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .coin5_raw(coin5_raw), .coin10_raw(coin10_raw),
    .commit(commit), .coin_code(coin_code), .busy(busy), .count(count),
    .full(full), .reject(reject)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs sampled there, then compare.
  task automatic tick();
    bit e5, e10, push, open, was_collect;
    int old_quiet;
    @(posedge clk);
    if (rst) begin
      q.delete();
      bursting = 0; in_gap = 0; quiet = 0;
      run5 = 0; run10 = 0; hit5 = 3'b000; hit10 = 3'b000;
      exp_code = 0; exp_rej = 0;
    end else begin
      // A coin event appears 3 edges after the D-th consecutive high raw sample.
      e5  = hit5[2];
      e10 = hit10[2];
      run5  = coin5_raw  ? run5 + 1  : 0;
      run10 = coin10_raw ? run10 + 1 : 0;
      hit5  = {hit5[1:0],  1'(run5 == D)};
      hit10 = {hit10[1:0], 1'(run10 == D)};

      open = !bursting && !in_gap;
      push = (e5 ^ e10) && open && (q.size() < DEPTH);
      exp_rej = ((e5 || e10) && !push) ? 1 : 0;
      exp_code = 0;
      if (in_gap) begin
        in_gap = 0;
      end else if (bursting) begin
        if (q.size() > 0) exp_code = q.pop_front();
        else begin bursting = 0; in_gap = 1; end
      end else begin
        was_collect = q.size() > 0;
        old_quiet = quiet;
        if (push) begin q.push_back(e5 ? 1 : 2); quiet = TO; end
        else if (quiet > 0) quiet--;
        if (was_collect && (commit || old_quiet == 0 || q.size() == DEPTH)) bursting = 1;
      end
    end
    exp_busy  = (bursting || in_gap) ? 1 : 0;
    exp_count = q.size();
    exp_full  = (q.size() == DEPTH) ? 1 : 0;
    #1;
    check("coin_code", {6'd0, coin_code}, 8'(exp_code));
    check("busy", {7'd0, busy}, 8'(exp_busy));
    check("count", 8'(count), 8'(exp_count));
    check("full", {7'd0, full}, 8'(exp_full));
    check("reject", {7'd0, reject}, 8'(exp_rej));
    if (reject === 1'b1) rejects_seen++;
  endtask

  task automatic drive(input bit c5, input bit c10, input bit cm, input bit r);
    coin5_raw = c5; coin10_raw = c10; commit = cm; rst = r;
    tick();
  endtask

  initial begin
    int rem5, rem10;
    rst = 1'b1; coin5_raw = 1'b0; coin10_raw = 1'b0; commit = 1'b0;

    // Reset state
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1);

    // Single 5 rs coin held 30 cycles, then commit
    for (int i = 0; i < 36; i++) drive(i < 30, 0, i == 33, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 0, 0);

    // 5 rs then 10 rs, then commit
    for (int i = 0; i < 48; i++) drive(i < 17, i >= 18 && i < 35, i == 40, 0);

    // Idle timeout with one 10 rs coin
    for (int i = 0; i < 60; i++) drive(0, i < 20, 0, 0);

    // Four coins fill the FIFO; a 10 rs coin lands during the burst
    rejects_seen = 0;
    for (int i = 0; i < 96; i++)
      drive((i % 18) < 17 && i < 71, i >= 56 && i < 80, 0, 0);
    check("fill_reject_pulses", 8'(rejects_seen), 8'd1);

    // Both lines rising together, then a 10-cycle glitch on coin5
    rejects_seen = 0;
    for (int i = 0; i < 70; i++) drive(i < 20 || (i >= 30 && i < 40), i < 20, 0, 0);
    check("dual_reject_pulses", 8'(rejects_seen), 8'd1);

    // Reset on the second burst cycle: second coin never appears
    for (int i = 0; i < 60; i++) drive(i < 17, i >= 18 && i < 35, i == 40, i == 42);

    // Random coins, commits and occasional resets
    rem5 = 0; rem10 = 0;
    for (int i = 0; i < 4000; i++) begin
      if (rem5 == 0 && $urandom_range(0, 39) == 0) rem5 = $urandom_range(1, 40);
      if (rem10 == 0 && $urandom_range(0, 39) == 0) rem10 = $urandom_range(1, 40);
      drive(rem5 > 0, rem10 > 0, $urandom_range(0, 29) == 0, $urandom_range(0, 1499) == 0);
      if (rem5 > 0) rem5--;
      if (rem10 > 0) rem10--;
    end
    for (int i = 0; i < 60; i++) drive(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
